// File: rtl/trap_sequencer_pkg.sv
// Shared encodings for the trap sequencer and the machine-mode CSR unit.
package trap_sequencer_pkg;

  // XLEN width encoding: data width W = 1 << (XLEN + 4).
  localparam logic [1:0] XLEN_32B = 2'd1;
  localparam logic [1:0] XLEN_64B = 2'd2;

  // Exception codes written to mcause.
  localparam int MCAUSE_INSN_MISALIGNED  = 0;
  localparam int MCAUSE_INSN_FAULT       = 1;
  localparam int MCAUSE_ILLEGAL          = 2;
  localparam int MCAUSE_BREAKPOINT       = 3;
  localparam int MCAUSE_LOAD_MISALIGNED  = 4;
  localparam int MCAUSE_LOAD_FAULT       = 5;
  localparam int MCAUSE_STORE_MISALIGNED = 6;
  localparam int MCAUSE_STORE_FAULT      = 7;
  localparam int MCAUSE_ECALL_M          = 11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_state_e;

  typedef enum logic {
    KIND_EXC  = 1'b0,
    KIND_MRET = 1'b1
  } trap_kind_e;

endpackage

// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer: arbitrates trap events, then walks
// FLUSH -> COMMIT -> REDIRECT around the machine-mode CSR file.
//
//   state       | meaning
//   ------------+-------------------------------------------------
//   ST_IDLE     | accepting events (E/M exc > mret > F/D exc)
//   ST_FLUSH    | stall + bubble F/D, D/E, E/M
//   ST_COMMIT   | stall, one CSR strobe (trap write or mret)
//   ST_REDIRECT | stall, fetch takes the redirect target
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter logic [1:0] XLEN     = XLEN_64B,
  parameter int         MCAUSE_W = 4,
  localparam int        W        = 1 << (int'(XLEN) + 4)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clk_en,
  input  logic                i_exc_valid_fd,
  input  logic [MCAUSE_W-1:0] i_exc_code_fd,
  input  logic [W-1:0]        i_exc_pc_fd,
  input  logic                i_exc_valid_em,
  input  logic [MCAUSE_W-1:0] i_exc_code_em,
  input  logic [W-1:0]        i_exc_pc_em,
  input  logic [W-1:0]        i_exc_addr_em,
  input  logic                i_mret_e,
  input  logic [W-1:0]        i_mtvec,
  input  logic [W-1:0]        i_mepc,
  output logic                o_busy,
  output logic                o_stall,
  output logic                o_flush,
  output logic                o_trap_we,
  output logic [W-1:0]        o_mepc_wr,
  output logic [W-1:0]        o_mcause_wr,
  output logic [W-1:0]        o_mtval_wr,
  output logic                o_mret_commit,
  output logic                o_redirect_valid,
  output logic [W-1:0]        o_redirect_pc
);

  trap_state_e state_q, state_d;
  trap_kind_e  kind_q, sel_kind;
  logic [W-1:0] epc_q, cause_q, tval_q;
  logic [W-1:0] sel_epc, sel_cause, sel_tval;
  logic         accept;
  logic         em_tval_en, fd_tval_en;

  // Faulting address is only meaningful for load/store misaligned/fault.
  assign em_tval_en = (i_exc_code_em >= MCAUSE_W'(MCAUSE_LOAD_MISALIGNED)) &&
                      (i_exc_code_em <= MCAUSE_W'(MCAUSE_STORE_FAULT));
  // Fetch-side faults report the faulting PC as tval.
  assign fd_tval_en = (i_exc_code_fd == MCAUSE_W'(MCAUSE_INSN_MISALIGNED)) ||
                      (i_exc_code_fd == MCAUSE_W'(MCAUSE_INSN_FAULT)) ||
                      (i_exc_code_fd == MCAUSE_W'(MCAUSE_BREAKPOINT));

  // State and captured trap record; reset aborts any sequence in flight.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_EXC;
      epc_q   <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else if (i_clk_en) begin
      state_q <= state_d;
      if (accept) begin
        kind_q  <= sel_kind;
        epc_q   <= sel_epc;
        cause_q <= sel_cause;
        tval_q  <= sel_tval;
      end
    end
  end

  // Priority select, next state and state-decoded outputs.
  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    sel_kind         = KIND_EXC;
    sel_epc          = '0;
    sel_cause        = '0;
    sel_tval         = '0;
    o_busy           = 1'b0;
    o_stall          = 1'b0;
    o_flush          = 1'b0;
    o_trap_we        = 1'b0;
    o_mret_commit    = 1'b0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    o_mepc_wr        = '0;
    o_mcause_wr      = '0;
    o_mtval_wr       = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_exc_valid_em) begin
          accept    = 1'b1;
          sel_epc   = i_exc_pc_em;
          sel_cause = {{(W-MCAUSE_W){1'b0}}, i_exc_code_em};
          sel_tval  = em_tval_en ? i_exc_addr_em : '0;
        end else if (i_mret_e) begin
          accept   = 1'b1;
          sel_kind = KIND_MRET;
        end else if (i_exc_valid_fd) begin
          accept    = 1'b1;
          sel_epc   = i_exc_pc_fd;
          sel_cause = {{(W-MCAUSE_W){1'b0}}, i_exc_code_fd};
          sel_tval  = fd_tval_en ? i_exc_pc_fd : '0;
        end
        if (accept) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_d = ST_COMMIT;
        o_busy  = 1'b1;
        o_stall = 1'b1;
        o_flush = 1'b1;
      end
      ST_COMMIT: begin
        state_d       = ST_REDIRECT;
        o_busy        = 1'b1;
        o_stall       = 1'b1;
        o_trap_we     = i_clk_en && (kind_q == KIND_EXC);
        o_mret_commit = i_clk_en && (kind_q == KIND_MRET);
      end
      ST_REDIRECT: begin
        state_d          = ST_IDLE;
        o_busy           = 1'b1;
        o_stall          = 1'b1;
        o_redirect_valid = i_clk_en;
        // Direct mode only: no interrupts, so mtvec mode bits are dropped.
        if (i_clk_en) o_redirect_pc = (kind_q == KIND_EXC) ? (i_mtvec & ~W'(3))
                                                            : (i_mepc & ~W'(1));
      end
      default: state_d = ST_IDLE;
    endcase

    if (o_trap_we) begin
      o_mepc_wr   = epc_q;
      o_mcause_wr = cause_q;
      o_mtval_wr  = tval_q;
    end

    // Outputs are quiet for as long as reset is held, not just after the edge.
    if (!i_rst) begin
      o_busy           = 1'b0;
      o_stall          = 1'b0;
      o_flush          = 1'b0;
      o_trap_we        = 1'b0;
      o_mret_commit    = 1'b0;
      o_redirect_valid = 1'b0;
      o_redirect_pc    = '0;
      o_mepc_wr        = '0;
      o_mcause_wr      = '0;
      o_mtval_wr       = '0;
    end
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Arbitrates trap events from the pipeline and sequences trap entry and exit around the machine-mode CSR file.
- Trap events are: F/D exceptions, E/M exceptions, and mret from Execute.
- For each accepted event it flushes and stalls the pipeline, then issues one CSR commit strobe (mepc/mcause/mtval, or mret), then redirects fetch.
- Sits between the hazard unit, the CSR unit and the PC-select mux.

Parameters:
XLEN, `XLEN_64b, 2-bit width encoding; data width W = 1<<(XLEN+4).
MCAUSE_W, 4, width of the exception code field.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-low
i_clk_en  in  1  global clock enable; when low, all state holds and strobes are forced to 0
i_exc_valid_fd  in  1  F/D-stage exception pending
i_exc_code_fd  in  4  F/D exception code
i_exc_pc_fd  in  W  F/D faulting PC
i_exc_valid_em  in  1  E/M-stage exception pending
i_exc_code_em  in  4  E/M exception code
i_exc_pc_em  in  W  E/M faulting PC
i_exc_addr_em  in  W  E/M faulting data address
i_mret_e  in  1  mret in Execute
i_mtvec  in  W  current mtvec
i_mepc  in  W  current mepc
o_busy  out  1  sequencer not IDLE
o_stall  out  1  freeze PC and all pipeline registers
o_flush  out  1  bubble F/D, D/E, E/M registers
o_trap_we  out  1  one-cycle strobe: CSR file writes mepc/mcause/mtval
o_mepc_wr  out  W  value for mepc
o_mcause_wr  out  W  value for mcause
o_mtval_wr  out  W  value for mtval
o_mret_commit  out  1  one-cycle strobe: CSR file restores MIE from MPIE
o_redirect_valid  out  1  fetch takes o_redirect_pc
o_redirect_pc  out  W  redirect target

Behaviour:
- Reset: synchronous, active-low (i_rst==0 at a rising edge). It forces state IDLE and zeroes all captured registers. Every output is 0 during and after reset.
- States: IDLE -> FLUSH -> COMMIT -> REDIRECT -> IDLE. Each state lasts exactly one enabled cycle.
- Transitions advance only when i_clk_en=1. When i_clk_en=0, state and captured registers hold. o_trap_we, o_mret_commit and o_redirect_valid are 0; o_stall and o_flush keep their state-decoded value.
- Acceptance, IDLE only, by priority:
  1. E/M exception (oldest instruction).
  2. mret.
  3. F/D exception.
  - A lower-priority event in the same cycle is discarded; the flush removes it.
- On acceptance, capture:
  - kind (EXC/MRET)
  - epc: pc_em or pc_fd
  - cause: zero-extended code, bit W-1 = 0 (no interrupts)
  - tval:
    - E/M: addr_em for codes 4-7, else 0.
    - F/D: pc_fd for codes 0,1,3, else 0.
- FLUSH: o_stall=1, o_flush=1, o_busy=1.
- COMMIT: o_stall=1, o_busy=1.
  - EXC: o_trap_we=1 with captured epc/cause/tval on the *_wr buses.
  - MRET: o_mret_commit=1.
  - The *_wr buses are 0 when o_trap_we=0.
- REDIRECT: o_redirect_valid=1, o_stall=1, o_busy=1.
  - EXC target: {i_mtvec[W-1:2],2'b00}. Vectored mode is ignored because there are no interrupts.
  - MRET target: {i_mepc[W-1:1],1'b0}, sampled in this cycle.
- Fixed latency: event sampled at edge N -> flush in cycle N+1, CSR strobe N+2, redirect N+3, IDLE N+4. A new event is earliest accepted at edge N+4.
- Event inputs are ignored while not IDLE; the pipeline is stalled or flushed, so no new events are legitimate.
- Reset mid-sequence aborts immediately: no strobe, no redirect.
- A trap inside the handler is handled normally. mepc is overwritten; there is no nesting detection.

Decomposition:
- Shared package/header: state encodings, kind encoding, and the MCAUSE code constants (misaligned-fetch 0, access-fault 1, illegal 2, breakpoint 3, load/store 4-7, ecall-M 11) reused by the CSR unit.
- No sub-module needed. The priority/capture mux and FSM stay in one block, about 200 lines.

Test Plan:
1. Reset: hold i_rst=0 with all valids=1 -> all outputs 0. Release -> IDLE, o_busy=0.
2. F/D illegal: i_exc_valid_fd=1, code=2, pc=0x80 -> flush at N+1; o_trap_we at N+2 with mepc=0x80, mcause=2, mtval=0; redirect at N+3 to mtvec(0x1001) -> 0x1000.
3. Simultaneous events: E/M load fault (code 5, pc=0x200, addr=0xDEAD) + mret + F/D exception in one cycle -> single sequence, mepc=0x200, mcause=5, mtval=0xDEAD, no o_mret_commit.
4. mret: i_mret_e=1, i_mepc=0x203 -> o_mret_commit at N+2, o_trap_we never set, redirect to 0x202.
5. Clock enable: drop i_clk_en for 3 cycles during COMMIT -> no strobe while low. On re-enable the strobe fires once, redirect follows one cycle later.
6. Reset mid-sequence: assert i_rst=0 in FLUSH -> next cycle IDLE, no o_trap_we, no o_redirect_valid.
